sr595_chain_driver: RTL and testbench



---
 rtl/sr595_pkg.sv | 18 +
 rtl/sr595_clkdiv.sv | 37 +++
 rtl/sr595_chain_driver.sv | 123 ++++++++++++
 tb/tb_sr595_chain_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sr595_pkg.sv
// Shared types and helpers for the 74x595 chain driver.
package sr595_pkg;

    localparam int BITS_PER_595 = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO
    } state_e;

    function automatic int div_width(input int clkdiv);
        return (clkdiv < 1) ? 1 : $clog2(clkdiv + 1);
    endfunction

endpackage

// File: rtl/sr595_clkdiv.sv
// Half-period tick generator: counts 0..CLKDIV-1 and pulses tick_o on the terminal count.
module sr595_clkdiv
    import sr595_pkg::*;
#(
    parameter int CLKDIV = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_o
);

    localparam int DW = div_width(CLKDIV);
    localparam logic [DW-1:0] LAST = DW'(CLKDIV - 1);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + DW'(1);
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sr595_chain_driver.sv
// Drives SER/SRCLK/RCLK/OE_n for a daisy chain of 74x595 parts from a valid/ready word.
// Define SR595_OE_BLANK_EN to blank the 595 outputs while a word is being shifted and latched.
//
// state    | meaning
// IDLE     | ready for a word, outputs live once anything has been latched
// SHIFT_LO | srclk low, current bit presented on ser
// SHIFT_HI | srclk high, bit clocked into the chain
// LATCH_HI | rclk high, chain copied to the storage registers
// LATCH_LO | rclk low, recovery before the next word
module sr595_chain_driver
    import sr595_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 2
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             ser,
    output logic             srclk,
    output logic             rclk,
    output logic             oe_n,
    output logic             busy
);

    localparam int BCW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic             latched_q, latched_d;
    logic             tick;
    logic             oe_n_d;

    // The divider is held at zero in IDLE so every state is entered with a fresh count.
    sr595_clkdiv #(
        .CLKDIV (CLKDIV)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .restart_i (state_q == IDLE),
        .tick_o    (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        latched_d = latched_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    shreg_d  = data_in;
                    bitcnt_d = BCW'(WIDTH - 1);
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (tick) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (bitcnt_q == '0) begin
                        state_d = LATCH_HI;
                    end else begin
                        shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                        bitcnt_d = bitcnt_q - BCW'(1);
                        state_d  = SHIFT_LO;
                    end
                end
            end
            LATCH_HI: begin
                if (tick) state_d = LATCH_LO;
            end
            LATCH_LO: begin
                if (tick) begin
                    state_d   = IDLE;
                    latched_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef SR595_OE_BLANK_EN
        oe_n_d = !(latched_d && (state_d == IDLE));
`else
        oe_n_d = !latched_d;
`endif
    end

    // Board-facing pins are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            latched_q <= 1'b0;
            ready     <= 1'b1;
            ser       <= 1'b0;
            srclk     <= 1'b0;
            rclk      <= 1'b0;
            oe_n      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            latched_q <= latched_d;
            ready     <= (state_d == IDLE);
            ser       <= shreg_d[WIDTH-1];
            srclk     <= (state_d == SHIFT_HI);
            rclk      <= (state_d == LATCH_HI);
            oe_n      <= oe_n_d;
        end
    end

    assign busy = !ready;

endmodule

// File: tb/tb_sr595_chain_driver.sv
// Directed bench for sr595_chain_driver: three configurations, each with a behavioural 595 chain.
module tb_sr595_chain_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a: WIDTH=8 CLKDIV=2, b: WIDTH=16 CLKDIV=2, c: WIDTH=8 CLKDIV=1
    logic [7:0]  d_a = '0;
    logic [15:0] d_b = '0;
    logic [7:0]  d_c = '0;
    logic v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
    logic rdy_a, ser_a, sck_a, rck_a, oe_a, bsy_a;
    logic rdy_b, ser_b, sck_b, rck_b, oe_b, bsy_b;
    logic rdy_c, ser_c, sck_c, rck_c, oe_c, bsy_c;

    sr595_chain_driver #(.WIDTH(8), .CLKDIV(2)) u_a (
        .clk(clk), .rst(rst), .data_in(d_a), .valid(v_a), .ready(rdy_a),
        .ser(ser_a), .srclk(sck_a), .rclk(rck_a), .oe_n(oe_a), .busy(bsy_a));

    sr595_chain_driver #(.WIDTH(16), .CLKDIV(2)) u_b (
        .clk(clk), .rst(rst), .data_in(d_b), .valid(v_b), .ready(rdy_b),
        .ser(ser_b), .srclk(sck_b), .rclk(rck_b), .oe_n(oe_b), .busy(bsy_b));

    sr595_chain_driver #(.WIDTH(8), .CLKDIV(1)) u_c (
        .clk(clk), .rst(rst), .data_in(d_c), .valid(v_c), .ready(rdy_c),
        .ser(ser_c), .srclk(sck_c), .rclk(rck_c), .oe_n(oe_c), .busy(bsy_c));

    // Behavioural 595 chains: bit WIDTH-1 of the shift chain is the farthest QH.
    logic [7:0]  sr_a = '0, q_a = '0;
    logic [15:0] sr_b = '0, q_b = '0;
    logic [7:0]  sr_c = '0, q_c = '0;
    int sck_n_a = 0, rck_n_a = 0, sck_n_b = 0, rck_n_b = 0, sck_n_c = 0, rck_n_c = 0;
    time t_prev_c = 0, t_last_c = 0;

    always @(posedge sck_a) begin sr_a <= {sr_a[6:0], ser_a};  sck_n_a++; end
    always @(posedge rck_a) begin q_a  <= sr_a;                 rck_n_a++; end
    always @(posedge sck_b) begin sr_b <= {sr_b[14:0], ser_b}; sck_n_b++; end
    always @(posedge rck_b) begin q_b  <= sr_b;                 rck_n_b++; end
    always @(posedge sck_c) begin
        sr_c <= {sr_c[6:0], ser_c};
        sck_n_c++;
        t_prev_c = t_last_c;
        t_last_c = $time;
    end
    always @(posedge rck_c) begin q_c <= sr_c; rck_n_c++; end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int d);
        case (d)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic get_oe(input int d);
        case (d)
            0:       return oe_a;
            1:       return oe_b;
            default: return oe_c;
        endcase
    endfunction

    // Called at the negedge right after the accept edge; cyc = edges from accept to ready high.
    task automatic wait_ready(input int d, output int cyc, output int oe_low);
        cyc    = 0;
        oe_low = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!get_ready(d) && !get_oe(d)) oe_low++;
        end while (!get_ready(d) && cyc < 500);
        check_eq($sformatf("ready_timeout_%0d", d), 32'(get_ready(d)), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int cyc, oe_low, base;
    int exp_oe_a, exp_oe_b;

    initial begin
`ifdef SR595_OE_BLANK_EN
        exp_oe_a = 0;
        exp_oe_b = 0;
`else
        exp_oe_a = 35;
        exp_oe_b = 67;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset: {ready, ser, srclk, rclk, oe_n, busy}
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_outputs", {26'd0, rdy_a, ser_a, sck_a, rck_a, oe_a, bsy_a}, 32'b100010);
        end

        // 8'hA5, one-cycle valid pulse
        d_a = 8'hA5; v_a = 1'b1;
        @(posedge clk); #1 v_a = 1'b0;
        @(negedge clk);
        check_eq("a5_busy", 32'(bsy_a), 32'd1);
        wait_ready(0, cyc, oe_low);
        check_eq("a5_len", 32'(cyc), 32'd36);
        check_eq("a5_oe_first", 32'(oe_low), 32'd0);
        check_eq("a5_ser_seq", 32'(sr_a), 32'hA5);
        check_eq("a5_srclk_n", 32'(sck_n_a), 32'd8);
        check_eq("a5_rclk_n", 32'(rck_n_a), 32'd1);
        check_eq("a5_q", 32'(q_a), 32'hA5);
        check_eq("a5_oe_idle", 32'(oe_a), 32'd0);

        // 8'h55 latched, then reset during bit 3 of 8'h0F
        d_a = 8'h55; v_a = 1'b1;
        @(posedge clk); #1 v_a = 1'b0;
        @(negedge clk);
        wait_ready(0, cyc, oe_low);
        check_eq("55_q", 32'(q_a), 32'h55);
        check_eq("55_oe_live", 32'(oe_low), 32'(exp_oe_a));

        d_a = 8'h0F; v_a = 1'b1;
        base = sck_n_a;
        @(posedge clk); #1 v_a = 1'b0;
        for (int i = 0; i < 100 && (sck_n_a - base) < 3; i++) @(negedge clk);
        check_eq("rst_reach_bit3", 32'(sck_n_a - base), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_outputs", {27'd0, rdy_a, sck_a, rck_a, oe_a, ser_a}, 32'b10010);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_q_kept", 32'(q_a), 32'h55);
        check_eq("rst_rclk_n", 32'(rck_n_a), 32'd2);

        // WIDTH=16, valid held high: 16'h1234 then 16'hFFFF
        d_b = 16'h1234; v_b = 1'b1;
        @(posedge clk); #1 d_b = 16'hFFFF;
        @(negedge clk);
        wait_ready(1, cyc, oe_low);
        check_eq("b1_len", 32'(cyc), 32'd68);
        check_eq("b1_q", 32'(q_b), 32'h1234);
        check_eq("b_oe_gap", 32'(oe_b), 32'd0);
        @(negedge clk);
        check_eq("b2_accepted", 32'(bsy_b), 32'd1);
        v_b = 1'b0;
        wait_ready(1, cyc, oe_low);
        check_eq("b2_len", 32'(cyc), 32'd68);
        check_eq("b2_oe_live", 32'(oe_low), 32'(exp_oe_b));
        check_eq("b2_q", 32'(q_b), 32'hFFFF);
        check_eq("b_srclk_n", 32'(sck_n_b), 32'd32);
        check_eq("b_rclk_n", 32'(rck_n_b), 32'd2);

        // CLKDIV=1, 8'h80
        d_c = 8'h80; v_c = 1'b1;
        @(posedge clk); #1 v_c = 1'b0;
        @(negedge clk);
        wait_ready(2, cyc, oe_low);
        check_eq("c_len", 32'(cyc), 32'd18);
        check_eq("c_period", 32'(t_last_c - t_prev_c), 32'd20);
        check_eq("c_ser_seq", 32'(sr_c), 32'h80);
        check_eq("c_srclk_n", 32'(sck_n_c), 32'd8);
        check_eq("c_q", 32'(q_c), 32'h80);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
